// File: rtl/ram_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// ram_arbiter_pkg
// Shared types and constants for the two-port RAM arbiter.
//   port_id_t    : identifies requester 0 or 1
//   READ_LATENCY : cycles from read transfer to rvalid (issue + response stage)
//   req_tag_t    : request record carried down the issue/response pipeline
// -----------------------------------------------------------------------------
package ram_arbiter_pkg;

   typedef logic port_id_t;

   localparam port_id_t PORT0 = 1'b0;
   localparam port_id_t PORT1 = 1'b1;

   localparam int READ_LATENCY = 2;

   typedef struct packed {
      logic     valid;
      logic     we;
      port_id_t id;
   } req_tag_t;

endpackage

// File: rtl/ram_arbiter_if.sv
// -----------------------------------------------------------------------------
// ram_arbiter_if
// One requester port of the RAM arbiter.
//   valid/ready : access handshake, transfer when both are 1
//   we          : 1 = write, 0 = read
//   addr/wdata  : access address and write data
//   rvalid/rdata: read response, no backpressure
// master = requester side, slave = arbiter side.
// -----------------------------------------------------------------------------
interface ram_arbiter_if #(
   parameter int addr_width = 9,
   parameter int data_width = 8
);
   logic                  valid;
   logic                  ready;
   logic                  we;
   logic [addr_width-1:0] addr;
   logic [data_width-1:0] wdata;
   logic                  rvalid;
   logic [data_width-1:0] rdata;

   modport master (output valid, we, addr, wdata, input  ready, rvalid, rdata);
   modport slave  (input  valid, we, addr, wdata, output ready, rvalid, rdata);
endinterface

// File: rtl/rr_arbiter2.sv
// -----------------------------------------------------------------------------
// rr_arbiter2
// Two-input round-robin grant logic with its priority pointer.
//   clk, rst : clock, asynchronous active-high reset
//   req_i    : request per port
//   grant_o  : one-hot grant, combinational from req_i and the pointer,
//              forced to zero while rst is high
// The pointer remembers the most recently granted port; on contention the
// other port wins. After reset it points at port 1 so port 0 wins first.
// -----------------------------------------------------------------------------
module rr_arbiter2
   import ram_arbiter_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] req_i,
   output logic [1:0] grant_o
);

   port_id_t last_q;
   port_id_t last_d;

   // NOTE: every signal driven in always_comb gets a default first, so no latch is inferred.
   always_comb begin
      grant_o = 2'b00;
      if (!rst) begin
         case (req_i)
            2'b01:   grant_o = 2'b01;
            2'b10:   grant_o = 2'b10;
            2'b11:   grant_o = (last_q == PORT0) ? 2'b10 : 2'b01;
            default: grant_o = 2'b00;
         endcase
      end
   end

   // A grant is always a transfer (grant implies valid), so the pointer
   // moves exactly on transfers.
   always_comb begin
      last_d = last_q;
      if (grant_o != 2'b00) last_d = grant_o[1];
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) last_q <= PORT1;
      else     last_q <= last_d;
   end

endmodule

// File: rtl/ram_arbiter.sv
// -----------------------------------------------------------------------------
// ram_arbiter
// Arbitrates two requesters onto one external registered-output RAM.
//   clk, rst     : clock, asynchronous active-high reset
//   p0, p1       : requester ports (ram_arbiter_if.slave)
//   ram_write_en : RAM write enable        (registered)
//   ram_waddr    : RAM write address       (registered, holds when idle)
//   ram_din      : RAM write data          (registered, holds when idle)
//   ram_raddr    : RAM read address        (registered, holds when idle)
//   ram_dout     : RAM read data, one cycle after ram_raddr is sampled
// Transfer in cycle T -> RAM access presented in T+1 -> rvalid/rdata in T+2.
// -----------------------------------------------------------------------------
module ram_arbiter
   import ram_arbiter_pkg::*;
#(
   parameter int addr_width = 9,
   parameter int data_width = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   ram_arbiter_if.slave          p0,
   ram_arbiter_if.slave          p1,
   output logic                  ram_write_en,
   output logic [addr_width-1:0] ram_waddr,
   output logic [data_width-1:0] ram_din,
   output logic [addr_width-1:0] ram_raddr,
   input  logic [data_width-1:0] ram_dout
);

   logic [1:0]            grant;
   logic                  xfer;
   port_id_t              sel_id;
   logic                  sel_we;
   logic [addr_width-1:0] sel_addr;
   logic [data_width-1:0] sel_wdata;

   logic                  ram_write_en_q;
   logic [addr_width-1:0] ram_waddr_q;
   logic [data_width-1:0] ram_din_q;
   logic [addr_width-1:0] ram_raddr_q;

   // tag_q[0] is the issue stage, tag_q[READ_LATENCY-1] the response stage.
   req_tag_t              tag_q [READ_LATENCY];
   req_tag_t              issue_d;
   req_tag_t              rsp;
   logic [1:0]            rvalid;
   logic [data_width-1:0] p0_rdata_q;
   logic [data_width-1:0] p1_rdata_q;

   rr_arbiter2 u_arb (
      .clk     (clk),
      .rst     (rst),
      .req_i   ({p1.valid, p0.valid}),
      .grant_o (grant)
   );

   assign p0.ready = grant[0];
   assign p1.ready = grant[1];

   // Grant is one-hot, so grant[1] alone selects the winning port.
   assign xfer      = |grant;
   assign sel_id    = grant[1];
   assign sel_we    = sel_id ? p1.we    : p0.we;
   assign sel_addr  = sel_id ? p1.addr  : p0.addr;
   assign sel_wdata = sel_id ? p1.wdata : p0.wdata;

   assign issue_d = '{valid: xfer, we: sel_we, id: sel_id};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ram_write_en_q <= 1'b0;
         ram_waddr_q    <= '0;
         ram_din_q      <= '0;
         ram_raddr_q    <= '0;
         for (int i = 0; i < READ_LATENCY; i++) tag_q[i] <= '0;
      end else begin
         ram_write_en_q <= xfer && sel_we;
         if (xfer && sel_we) begin
            ram_waddr_q <= sel_addr;
            ram_din_q   <= sel_wdata;
         end
         if (xfer && !sel_we) ram_raddr_q <= sel_addr;
         tag_q[0] <= issue_d;
         for (int i = 1; i < READ_LATENCY; i++) tag_q[i] <= tag_q[i-1];
      end
   end

   assign ram_write_en = ram_write_en_q;
   assign ram_waddr    = ram_waddr_q;
   assign ram_din      = ram_din_q;
   assign ram_raddr    = ram_raddr_q;

   // Writes travel down the pipeline too but never raise rvalid.
   assign rsp       = tag_q[READ_LATENCY-1];
   assign rvalid[0] = rsp.valid && !rsp.we && (rsp.id == PORT0);
   assign rvalid[1] = rsp.valid && !rsp.we && (rsp.id == PORT1);

   // ram_dout is only meaningful in the response cycle; capture it there so
   // rdata keeps showing the last response afterwards.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         p0_rdata_q <= '0;
         p1_rdata_q <= '0;
      end else begin
         if (rvalid[0]) p0_rdata_q <= ram_dout;
         if (rvalid[1]) p1_rdata_q <= ram_dout;
      end
   end

   assign p0.rvalid = rvalid[0];
   assign p1.rvalid = rvalid[1];
   assign p0.rdata  = rvalid[0] ? ram_dout : p0_rdata_q;
   assign p1.rdata  = rvalid[1] ? ram_dout : p1_rdata_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// -----------------------------------------------------------------------------
// tb_ram_arbiter
// Bench for ram_arbiter: a default (9-bit address) instance with a RAM model,
// driven by directed and random requesters and compared every cycle against a
// transaction-level reference, plus a 13-bit address instance for the wide case.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_ram_arbiter;

   localparam int AW  = 9;
   localparam int AWB = 13;
   localparam int DW  = 8;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // ---------------- default-width instance ----------------
   ram_arbiter_if #(.addr_width(AW), .data_width(DW)) a0 ();
   ram_arbiter_if #(.addr_width(AW), .data_width(DW)) a1 ();
   logic          ram_we_a;
   logic [AW-1:0] ram_waddr_a, ram_raddr_a;
   logic [DW-1:0] ram_din_a, ram_dout_a;
   logic [DW-1:0] mem_a [2**AW];

   ram_arbiter #(.addr_width(AW), .data_width(DW)) dut_a (
      .clk          (clk),
      .rst          (rst),
      .p0           (a0),
      .p1           (a1),
      .ram_write_en (ram_we_a),
      .ram_waddr    (ram_waddr_a),
      .ram_din      (ram_din_a),
      .ram_raddr    (ram_raddr_a),
      .ram_dout     (ram_dout_a)
   );

   always @(posedge clk) begin
      if (ram_we_a) mem_a[ram_waddr_a] <= ram_din_a;
      ram_dout_a <= mem_a[ram_raddr_a];
   end

   // ---------------- wide-address instance ----------------
   ram_arbiter_if #(.addr_width(AWB), .data_width(DW)) b0 ();
   ram_arbiter_if #(.addr_width(AWB), .data_width(DW)) b1 ();
   logic           ram_we_b;
   logic [AWB-1:0] ram_waddr_b, ram_raddr_b;
   logic [DW-1:0]  ram_din_b, ram_dout_b;
   logic [DW-1:0]  mem_b [2**AWB];

   ram_arbiter #(.addr_width(AWB), .data_width(DW)) dut_b (
      .clk          (clk),
      .rst          (rst),
      .p0           (b0),
      .p1           (b1),
      .ram_write_en (ram_we_b),
      .ram_waddr    (ram_waddr_b),
      .ram_din      (ram_din_b),
      .ram_raddr    (ram_raddr_b),
      .ram_dout     (ram_dout_b)
   );

   always @(posedge clk) begin
      if (ram_we_b) mem_b[ram_waddr_b] <= ram_din_b;
      ram_dout_b <= mem_b[ram_raddr_b];
   end

   // ---------------- checking ----------------
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Transaction-level reference for dut_a: an accepted access is presented
   // to the RAM one cycle later; a read answers two cycles later with the
   // memory contents as seen by the accepted-access order.
   typedef struct {
      bit v;
      bit we;
      int id;
      int addr;
      int wdata;
      int rdat;
      bit rk;
   } acc_t;

   acc_t i1, i2;
   int   last_grant = 1;
   int   exp_waddr = 0, exp_din = 0, exp_raddr = 0;
   int   exp_rdata [2] = '{0, 0};
   bit   exp_rk [2] = '{1'b1, 1'b1};
   int   ref_mem [2**AW];
   bit   ref_known [2**AW];
   bit [1:0] took;

   always @(negedge clk) begin : model
      int   g;
      acc_t cur;
      if (rst) begin
         check("rst_ready0", a0.ready, 0);
         check("rst_ready1", a1.ready, 0);
         check("rst_rvalid0", a0.rvalid, 0);
         check("rst_rvalid1", a1.rvalid, 0);
         check("rst_ram_write_en", ram_we_a, 0);
         check("rst_ram_waddr", ram_waddr_a, 0);
         check("rst_ram_raddr", ram_raddr_a, 0);
         check("rst_ram_din", ram_din_a, 0);
         check("rst_rdata0", a0.rdata, 0);
         check("rst_rdata1", a1.rdata, 0);
         i1.v = 1'b0;
         i2.v = 1'b0;
         last_grant = 1;
         exp_waddr = 0; exp_din = 0; exp_raddr = 0;
         exp_rdata[0] = 0; exp_rdata[1] = 0;
         exp_rk[0] = 1'b1; exp_rk[1] = 1'b1;
         took = 2'b00;
      end else begin
         g = -1;
         if (a0.valid && a1.valid) g = 1 - last_grant;
         else if (a0.valid)        g = 0;
         else if (a1.valid)        g = 1;
         check("ready0", a0.ready, g == 0);
         check("ready1", a1.ready, g == 1);
         check("ram_write_en", ram_we_a, i1.v && i1.we);
         check("ram_waddr", ram_waddr_a, exp_waddr);
         check("ram_din", ram_din_a, exp_din);
         check("ram_raddr", ram_raddr_a, exp_raddr);
         check("rvalid0", a0.rvalid, i2.v && i2.id == 0);
         check("rvalid1", a1.rvalid, i2.v && i2.id == 1);
         if (i2.v) begin
            exp_rdata[i2.id] = i2.rdat;
            exp_rk[i2.id]    = i2.rk;
         end
         if (exp_rk[0]) check("rdata0", a0.rdata, exp_rdata[0]);
         if (exp_rk[1]) check("rdata1", a1.rdata, exp_rdata[1]);
         // The write presented this cycle lands in the RAM at the next edge.
         if (i1.v && i1.we) begin
            ref_mem[i1.addr]   = i1.wdata;
            ref_known[i1.addr] = 1'b1;
         end
         i2 = i1;
         if (i1.we) i2.v = 1'b0;
         cur.v = (g >= 0);
         if (cur.v) begin
            cur.id    = g;
            cur.we    = (g == 0) ? a0.we : a1.we;
            cur.addr  = (g == 0) ? int'(a0.addr) : int'(a1.addr);
            cur.wdata = (g == 0) ? int'(a0.wdata) : int'(a1.wdata);
            cur.rdat  = ref_mem[cur.addr];
            cur.rk    = ref_known[cur.addr];
            last_grant = g;
            if (cur.we) begin
               exp_waddr = cur.addr;
               exp_din   = cur.wdata;
            end else begin
               exp_raddr = cur.addr;
            end
         end
         i1 = cur;
         took[0] = a0.valid && a0.ready;
         took[1] = a1.valid && a1.ready;
      end
   end

   // ---------------- stimulus helpers ----------------
   logic [AW-1:0] addr_tab [8] = '{9'h000, 9'h005, 9'h010, 9'h020, 9'h0AA, 9'h100, 9'h155, 9'h1FF};

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic set(input int port, input bit v, input bit we, input int addr, input int data);
      if (port == 0) begin
         a0.valid = v; a0.we = we; a0.addr = AW'(addr); a0.wdata = DW'(data);
      end else begin
         a1.valid = v; a1.we = we; a1.addr = AW'(addr); a1.wdata = DW'(data);
      end
   endtask

   task automatic setb(input int port, input bit v, input bit we, input int addr, input int data);
      if (port == 0) begin
         b0.valid = v; b0.we = we; b0.addr = AWB'(addr); b0.wdata = DW'(data);
      end else begin
         b1.valid = v; b1.we = we; b1.addr = AWB'(addr); b1.wdata = DW'(data);
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         cyc();
         set(0, 0, 0, 0, 0);
         set(1, 0, 0, 0, 0);
      end
   endtask

   // One uncontended transfer on the given port in the next cycle.
   task automatic single(input int port, input bit we, input int addr, input int data);
      cyc();
      set(port, 1, we, addr, data);
      set(1 - port, 0, 0, 0, 0);
      @(negedge clk);
      check($sformatf("single_ready%0d", port), (port == 0) ? a0.ready : a1.ready, 1);
   endtask

   task automatic new_req(input bit rd_only, output logic v, output logic we,
                          output logic [AW-1:0] addr, output logic [DW-1:0] wd);
      v    = rd_only ? 1'b1 : ($urandom_range(99) < 70);
      we   = rd_only ? 1'b0 : 1'($urandom_range(1));
      addr = addr_tab[$urandom_range(7)];
      wd   = DW'($urandom);
   endtask

   // Requesters keep an access stable until it transfers, then pick anew.
   task automatic drive_rand(input bit rd_only);
      cyc();
      if (!a0.valid || took[0]) new_req(rd_only, a0.valid, a0.we, a0.addr, a0.wdata);
      if (!a1.valid || took[1]) new_req(rd_only, a1.valid, a1.we, a1.addr, a1.wdata);
   endtask

   // ---------------- main sequence ----------------
   initial begin : stim
      int cnt0, cnt1, prev, g, consec;
      rst = 1'b1;
      set(0, 0, 0, 0, 0);  set(1, 0, 0, 0, 0);
      setb(0, 0, 0, 0, 0); setb(1, 0, 0, 0, 0);
      cyc(); cyc();
      rst = 1'b0;

      // Single write then read on port 0.
      cyc(); set(0, 1, 1, 'h05, 'hA5);
      @(negedge clk); check("wr_ready0", a0.ready, 1);
      cyc(); set(0, 1, 0, 'h05, 0);
      @(negedge clk);
      check("wr_en", ram_we_a, 1);
      check("wr_waddr", ram_waddr_a, 'h05);
      check("wr_din", ram_din_a, 'hA5);
      check("rd_ready0", a0.ready, 1);
      cyc(); set(0, 0, 0, 0, 0);
      @(negedge clk);
      check("rd_raddr", ram_raddr_a, 'h05);
      check("rd_no_wen", ram_we_a, 0);
      cyc(); @(negedge clk);
      check("rd_rvalid0", a0.rvalid, 1);
      check("rd_rdata0", a0.rdata, 'hA5);
      check("rd_rvalid1", a1.rvalid, 0);
      cyc(); @(negedge clk);
      check("rd_rvalid0_drop", a0.rvalid, 0);
      check("rd_rdata0_hold", a0.rdata, 'hA5);

      // Preload values used by later directed reads.
      single(1, 1, 'h10, 'h11);
      single(1, 1, 'h20, 'h22);
      single(0, 1, 'h0AA, 'h33);
      idle(3);

      // Read-after-write across ports.
      single(1, 1, 'h1FF, 'h3C);
      single(0, 0, 'h1FF, 0);
      idle(1);
      cyc(); @(negedge clk);
      check("raw_rvalid0", a0.rvalid, 1);
      check("raw_rdata0", a0.rdata, 'h3C);
      idle(2);

      // Contention from the first cycle after reset.
      cyc(); rst = 1'b1;
      cyc(); cyc();
      rst = 1'b0;
      set(0, 1, 0, 'h10, 0);
      set(1, 1, 0, 'h20, 0);
      @(negedge clk);
      check("cont_ready0_first", a0.ready, 1);
      check("cont_ready1_first", a1.ready, 0);
      cyc(); set(0, 0, 0, 0, 0);
      @(negedge clk);
      check("cont_ready1_second", a1.ready, 1);
      check("cont_ready0_second", a0.ready, 0);
      cyc(); set(1, 0, 0, 0, 0);
      @(negedge clk);
      check("cont_rvalid0", a0.rvalid, 1);
      check("cont_rdata0", a0.rdata, 'h11);
      check("cont_rvalid1_early", a1.rvalid, 0);
      cyc(); @(negedge clk);
      check("cont_rvalid1", a1.rvalid, 1);
      check("cont_rdata1", a1.rdata, 'h22);
      check("cont_rvalid0_late", a0.rvalid, 0);
      idle(2);

      // Fairness: both ports continuously valid for 20 cycles.
      cnt0 = 0; cnt1 = 0; prev = -1; consec = 0;
      for (int c = 0; c < 20; c++) begin
         drive_rand(1'b1);
         @(negedge clk);
         g = a0.ready ? 0 : (a1.ready ? 1 : -1);
         if (g == 0) cnt0++;
         if (g == 1) cnt1++;
         if (g >= 0 && g == prev) consec++;
         prev = g;
      end
      check("fair_grants0", cnt0, 10);
      check("fair_grants1", cnt1, 10);
      check("fair_consecutive", consec, 0);
      idle(4);

      // Reset with a read in flight.
      single(0, 0, 'h05, 0);
      cyc(); rst = 1'b1; set(0, 0, 0, 0, 0);
      @(negedge clk);
      check("rstfl_rvalid0_a", a0.rvalid, 0);
      check("rstfl_wen_a", ram_we_a, 0);
      cyc(); @(negedge clk);
      check("rstfl_rvalid0_b", a0.rvalid, 0);
      cyc(); rst = 1'b0;
      set(0, 1, 0, 'h05, 0);
      set(1, 1, 0, 'h20, 0);
      @(negedge clk);
      check("rstfl_ready0", a0.ready, 1);
      check("rstfl_ready1", a1.ready, 0);
      check("rstfl_rvalid0_c", a0.rvalid, 0);
      cyc(); set(0, 0, 0, 0, 0);
      @(negedge clk);
      check("rstfl_rvalid0_d", a0.rvalid, 0);
      check("rstfl_wen_d", ram_we_a, 0);
      cyc(); set(1, 0, 0, 0, 0);
      @(negedge clk);
      check("rstfl_rvalid0_new", a0.rvalid, 1);
      check("rstfl_rdata0_new", a0.rdata, 'hA5);
      idle(3);

      // A write whose issue cycle is hit by reset must not reach the RAM.
      single(1, 1, 'h0AA, 'h99);
      cyc(); rst = 1'b1; set(1, 0, 0, 0, 0);
      @(negedge clk);
      check("rstwr_wen", ram_we_a, 0);
      cyc(); cyc();
      rst = 1'b0;
      single(0, 0, 'h0AA, 0);
      idle(1);
      cyc(); @(negedge clk);
      check("rstwr_rvalid0", a0.rvalid, 1);
      check("rstwr_rdata0_old", a0.rdata, 'h33);
      idle(2);

      // Random traffic with a reset in the middle.
      for (int c = 0; c < 400; c++) drive_rand(1'b0);
      cyc(); rst = 1'b1;
      cyc(); cyc();
      rst = 1'b0;
      for (int c = 0; c < 400; c++) drive_rand(1'b0);
      idle(4);

      // Wide configuration on the 13-bit instance.
      cyc(); setb(1, 1, 1, 'h1FFF, 'h7E);
      @(negedge clk); check("wide_wr_ready1", b1.ready, 1);
      cyc(); setb(1, 1, 0, 'h1FFF, 0);
      @(negedge clk);
      check("wide_wen", ram_we_b, 1);
      check("wide_waddr", ram_waddr_b, 'h1FFF);
      check("wide_din", ram_din_b, 'h7E);
      check("wide_rd_ready1", b1.ready, 1);
      cyc(); setb(1, 0, 0, 0, 0);
      @(negedge clk);
      check("wide_raddr", ram_raddr_b, 'h1FFF);
      cyc(); @(negedge clk);
      check("wide_rvalid1", b1.rvalid, 1);
      check("wide_rdata1", b1.rdata, 'h7E);
      check("wide_rvalid0", b0.rvalid, 0);
      cyc(); cyc();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/ram_arbiter.md
RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 addr_width, default 9: RAM address width in bits, range 9..13.
REQ-002 data_width, default 8: RAM data width in bits.
REQ-003 clk  in  1: sole clock; all state updates on its rising edge.
REQ-004 rst  in  1: asynchronous, active-high reset.
REQ-005 pN_valid  in  1 (N=0,1): requester N presents an access.
REQ-006 pN_ready  out  1: access from requester N accepted this cycle.
REQ-007 pN_we  in  1: 1 = write, 0 = read.
REQ-008 pN_addr  in  addr_width: access address.
REQ-009 pN_wdata  in  data_width: write data, ignored for reads.
REQ-010 pN_rvalid  out  1: read data for requester N is valid this cycle.
REQ-011 pN_rdata  out  data_width: read data.
REQ-012 ram_write_en  out  1: RAM write enable.
REQ-013 ram_waddr  out  addr_width: RAM write address.
REQ-014 ram_din  out  data_width: RAM write data.
REQ-015 ram_raddr  out  addr_width: RAM read address.
REQ-016 ram_dout  in  data_width: RAM registered read data, 1-cycle latency from the raddr sample edge.

Function
REQ-017 Handshake: a transfer occurs in the cycle where pN_valid and pN_ready are both 1. pN_ready is combinational from both valids and the priority pointer, and at most one pN_ready is 1 per cycle.
REQ-018 pN_ready = 0 whenever pN_valid = 0. A requester holds valid/we/addr/wdata stable until its transfer.
REQ-019 Round-robin: only one valid -> that port is granted. Both valid -> the port not granted most recently is granted. The pointer updates only on a transfer.
REQ-020 No starvation: with both ports continuously valid, grants alternate 0,1,0,1,...
REQ-021 Issue stage: on the edge ending transfer cycle T, the RAM port registers load the access.
  - Write: ram_write_en=1, ram_waddr=addr, ram_din=wdata, all for cycle T+1.
  - Read: ram_write_en=0, ram_raddr=addr for cycle T+1.
  - No transfer: ram_write_en=0 in T+1.
  - ram_raddr, ram_waddr and ram_din hold their last value when idle.
REQ-022 Read response: the issue stage tags each read with its port id and passes the tag to a response stage. pN_rvalid=1 for exactly cycle T+2, with pN_rdata=ram_dout in that cycle. The other port's rvalid stays 0.
REQ-023 Writes generate no rvalid.
REQ-024 Throughput: one transfer per cycle sustained. Back-to-back reads give rvalid on consecutive cycles.
REQ-025 Ordering: a read accepted in the cycle after a write to the same address returns the new data.
REQ-026 Response has no backpressure: requesters always accept rvalid.
REQ-027 pN_rdata holds its last value when pN_rvalid=0.
REQ-028 Address wrap-around is not applicable: every address in 0..2^addr_width-1 is passed through unmodified.

Reset
REQ-029 While rst=1, and immediately on its assertion:
  - pN_rvalid=0 and ram_write_en=0;
  - issue and response valid flags cleared;
  - priority pointer set so port 0 wins the first contended cycle;
  - ram_waddr, ram_raddr, ram_din and pN_rdata cleared to 0;
  - pN_ready=0.
REQ-030 Reset mid-operation: in-flight reads are discarded and produce no rvalid after release. A write whose issue cycle is interrupted by reset is not performed.
REQ-031 The first transfer is possible in the first cycle with rst=0.

Structure
REQ-032 Shared package ram_arbiter_pkg holds the port-id type (1 bit), the READ_LATENCY constant (=2) and the request-record typedef.
REQ-033 Sub-module rr_arbiter2 contains the two-input round-robin grant logic and pointer register.
REQ-034 RAM storage lives outside this block, connected via the ram_* ports.

Verification
REQ-035 Single write then read: p0 writes addr 0x05 data 0xA5, then reads 0x05 -> ram_write_en=1 with waddr 0x05 one cycle after the write; p0_rvalid=1 with p0_rdata=0xA5 two cycles after the read transfer.
REQ-036 Contention: p0 and p1 both valid reads (0x10, 0x20) from the first cycle after reset -> p0 granted first, p1 next cycle; p0_rvalid then p1_rvalid on consecutive cycles, p1_rvalid never coincides with p0's tag.
REQ-037 Fairness: both ports continuously valid for 20 cycles -> grants alternate, 10 per port, never two consecutive grants to one port.
REQ-038 Read-after-write: p1 writes 0x1FF=0x3C, p0 reads 0x1FF the next cycle -> p0_rdata=0x3C.
REQ-039 Reset mid-flight: p0 read accepted, rst asserted the following cycle -> p0_rvalid stays 0, ram_write_en=0 throughout and after reset, and a contended first cycle after release grants port 0.
REQ-040 Wide configuration addr_width=13: write/read 0x1FFF=0x7E -> p1_rdata=0x7E.
